// File: rtl/doorlock_pkg.sv
// Shared types for the keypad door lock: PIN/config packets, controller states
// and the digit comparison helper used by the PIN matcher.
package doorlock_pkg;

    localparam logic [3:0] DIGIT_BLANK = 4'hE;

    typedef logic [3:0][3:0] pin_digits_t;

    typedef struct packed {
        logic        status;
        pin_digits_t digit;
    } pinPac_t;

    typedef struct packed {
        logic        status;
        pin_digits_t digit;
    } user_pin_t;

    // pins[0] is pin1 ... pins[3] is pin4
    typedef struct packed {
        user_pin_t [3:0] pins;
        pin_digits_t     master_pin;
        logic            bip_status;
        logic [6:0]      bip_time;
        logic [6:0]      tranca_aut_time;
    } setupPac_t;

    typedef enum logic [2:0] {
        TRAVADO,
        BLOQUEIO,
        DESTRAVADO,
        PORTA_ABERTA,
        SETUP
    } estado_ctrl_t;

    // A blank key position is stored and compared as digit 0.
    function automatic logic [3:0] norm_digit(input logic [3:0] d);
        return (d == DIGIT_BLANK) ? 4'h0 : d;
    endfunction

    function automatic logic pin_equal(input pin_digits_t a, input pin_digits_t b);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (norm_digit(a[i]) != norm_digit(b[i])) begin
                eq = 1'b0;
            end
        end
        return eq;
    endfunction

endpackage

// File: rtl/operacional_ctrl_if.sv
// Bus between the lock sequencer and its surroundings: keypad PIN, stored
// configuration, door/button inputs and the lock outputs.
interface operacional_ctrl_if;

    logic                   sec_tick;
    doorlock_pkg::pinPac_t   pin_in;
    doorlock_pkg::setupPac_t data_setup;
    logic                   sensor_porta;
    logic                   botao_interno;
    logic                   setup_done;
    logic                   tranca;
    logic                   bip;
    logic                   setup_on;
    logic                   bloqueado;
    logic [6:0]             seg_restante;

    modport master (
        output sec_tick, pin_in, data_setup, sensor_porta, botao_interno, setup_done,
        input  tranca, bip, setup_on, bloqueado, seg_restante
    );

    modport slave (
        input  sec_tick, pin_in, data_setup, sensor_porta, botao_interno, setup_done,
        output tranca, bip, setup_on, bloqueado, seg_restante
    );

endinterface

// File: rtl/pin_matcher.sv
// Combinational PIN check against the four user slots and the master PIN.
// Matches are only reported while the keypad presents an entry (status high).
module pin_matcher
    import doorlock_pkg::*;
(
    input  pinPac_t   pin_in,
    input  setupPac_t data_setup,
    output logic      match_user,
    output logic      match_master
);

    logic [3:0] slot_hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_hit[gi] = data_setup.pins[gi].status &&
                                  pin_equal(pin_in.digit, data_setup.pins[gi].digit);
        end
    endgenerate

    assign match_user   = pin_in.status && (|slot_hit);
    assign match_master = pin_in.status && pin_equal(pin_in.digit, data_setup.master_pin);

endmodule

// File: rtl/operacional_ctrl.sv
// Lock sequencer: bolt, door-open buzzer, failed-attempt lockout and the
// hand-off into setup mode. All outputs are registered.
module operacional_ctrl #(
    parameter int FAIL_T1 = 3,
    parameter int FAIL_T2 = 5,
    parameter int LOCK_T1 = 1,
    parameter int LOCK_T2 = 10,
    parameter int LOCK_T3 = 20
) (
    input  logic                clk,
    input  logic                rst,
    operacional_ctrl_if.slave   bus
);
    import doorlock_pkg::*;

    estado_ctrl_t state_reg;
    logic [3:0]   fail_cnt_reg;
    logic [6:0]   tmr_reg;
    logic [6:0]   seg_reg;
    logic         tranca_reg;
    logic         bip_reg;
    logic         setup_on_reg;
    logic         bloqueado_reg;
    logic         pin_status_reg;
    logic         botao_reg;

    logic         match_user;
    logic         match_master;
    logic         pin_edge;
    logic         botao_edge;
    logic [3:0]   fail_inc;
    logic [6:0]   lock_secs;
    logic         relock_due;
    logic [6:0]   open_tmr_next;

    pin_matcher u_matcher (
        .pin_in       (bus.pin_in),
        .data_setup   (bus.data_setup),
        .match_user   (match_user),
        .match_master (match_master)
    );

    assign pin_edge   = bus.pin_in.status & ~pin_status_reg;
    assign botao_edge = bus.botao_interno & ~botao_reg;
    assign fail_inc   = (fail_cnt_reg == 4'hF) ? 4'hF : fail_cnt_reg + 4'd1;

    always_comb begin
        lock_secs = 7'(LOCK_T1);
        if (int'(fail_inc) > FAIL_T2) begin
            lock_secs = 7'(LOCK_T3);
        end else if (int'(fail_inc) >= FAIL_T2) begin
            lock_secs = 7'(LOCK_T2);
        end
    end

    // ">=" rather than "==" so a zero or freshly lowered relock time still relocks.
    assign relock_due = bus.sec_tick &&
                        (({1'b0, tmr_reg} + 8'd1) >= {1'b0, bus.data_setup.tranca_aut_time});

    assign open_tmr_next = (bus.sec_tick && (tmr_reg != 7'd127)) ? tmr_reg + 7'd1 : tmr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= TRAVADO;
            fail_cnt_reg   <= '0;
            tmr_reg        <= '0;
            seg_reg        <= '0;
            tranca_reg     <= 1'b1;
            bip_reg        <= 1'b0;
            setup_on_reg   <= 1'b0;
            bloqueado_reg  <= 1'b0;
            pin_status_reg <= 1'b0;
            botao_reg      <= 1'b0;
        end else begin
            pin_status_reg <= bus.pin_in.status;
            botao_reg      <= bus.botao_interno;

            case (state_reg)
                TRAVADO: begin
                    // The button wins over a simultaneous PIN, which is then dropped.
                    if (botao_edge) begin
                        state_reg  <= DESTRAVADO;
                        tranca_reg <= 1'b0;
                        tmr_reg    <= '0;
                    end else if (pin_edge) begin
                        if (match_user || match_master) begin
                            state_reg    <= DESTRAVADO;
                            tranca_reg   <= 1'b0;
                            tmr_reg      <= '0;
                            fail_cnt_reg <= '0;
                        end else begin
                            fail_cnt_reg <= fail_inc;
                            if (int'(fail_inc) >= FAIL_T1) begin
                                state_reg     <= BLOQUEIO;
                                bloqueado_reg <= 1'b1;
                                seg_reg       <= lock_secs;
                            end
                        end
                    end
                end

                BLOQUEIO: begin
                    if (botao_edge) begin
                        state_reg     <= DESTRAVADO;
                        tranca_reg    <= 1'b0;
                        bloqueado_reg <= 1'b0;
                        seg_reg       <= '0;
                        tmr_reg       <= '0;
                    end else if (bus.sec_tick) begin
                        if (seg_reg <= 7'd1) begin
                            state_reg     <= TRAVADO;
                            bloqueado_reg <= 1'b0;
                            seg_reg       <= '0;
                        end else begin
                            seg_reg <= seg_reg - 7'd1;
                        end
                    end
                end

                DESTRAVADO: begin
                    if (bus.sensor_porta) begin
                        state_reg <= PORTA_ABERTA;
                        tmr_reg   <= '0;
                        bip_reg   <= bus.data_setup.bip_status &&
                                     (bus.data_setup.bip_time == 7'd0);
                    end else if (botao_edge || relock_due) begin
                        state_reg  <= TRAVADO;
                        tranca_reg <= 1'b1;
                    end else if (pin_edge && match_master) begin
                        state_reg    <= SETUP;
                        setup_on_reg <= 1'b1;
                        tmr_reg      <= '0;
                    end else if (bus.sec_tick) begin
                        tmr_reg <= tmr_reg + 7'd1;
                    end
                end

                PORTA_ABERTA: begin
                    if (!bus.sensor_porta) begin
                        state_reg <= DESTRAVADO;
                        bip_reg   <= 1'b0;
                        tmr_reg   <= '0;
                    end else begin
                        tmr_reg <= open_tmr_next;
                        bip_reg <= bus.data_setup.bip_status &&
                                   (open_tmr_next >= bus.data_setup.bip_time);
                    end
                end

                SETUP: begin
                    if (bus.setup_done) begin
                        state_reg    <= DESTRAVADO;
                        setup_on_reg <= 1'b0;
                        tmr_reg      <= '0;
                    end
                end

                default: begin
                    state_reg     <= TRAVADO;
                    tranca_reg    <= 1'b1;
                    bip_reg       <= 1'b0;
                    setup_on_reg  <= 1'b0;
                    bloqueado_reg <= 1'b0;
                    seg_reg       <= '0;
                    tmr_reg       <= '0;
                end
            endcase
        end
    end

    assign bus.tranca       = tranca_reg;
    assign bus.bip          = bip_reg;
    assign bus.setup_on     = setup_on_reg;
    assign bus.bloqueado    = bloqueado_reg;
    assign bus.seg_restante = seg_reg;

endmodule

// File: tb/tb_operacional_ctrl.sv
// Bench for operacional_ctrl: directed walk through the lock scenarios, then
// random stimulus checked every cycle against a rule-level model.
module tb_operacional_ctrl;
    import doorlock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operacional_ctrl_if bus ();

    operacional_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam int M_LOCKED   = 0;
    localparam int M_BLOCKED  = 1;
    localparam int M_UNLOCKED = 2;
    localparam int M_OPEN     = 3;
    localparam int M_SETUP    = 4;

    int m_mode, m_fail, m_secs, m_cnt;
    bit m_bip, m_pin_prev, m_btn_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int digit_val(input logic [3:0] d);
        return (d == 4'hE) ? 0 : int'(d);
    endfunction

    function automatic bit same_pin(input pin_digits_t a, input pin_digits_t b);
        for (int i = 0; i < 4; i++) begin
            if (digit_val(a[i]) != digit_val(b[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit any_user_slot(input pin_digits_t d, input setupPac_t cfg);
        for (int s = 0; s < 4; s++) begin
            if (cfg.pins[s].status && same_pin(d, cfg.pins[s].digit)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = M_LOCKED; m_fail = 0; m_secs = 0; m_cnt = 0;
        m_bip = 0; m_pin_prev = 0; m_btn_prev = 0;
    endtask

    task automatic model_step();
        bit pe, be, valid, master;
        if (!rst) begin
            model_reset();
            return;
        end
        pe = bus.pin_in.status && !m_pin_prev;
        be = bus.botao_interno && !m_btn_prev;
        m_pin_prev = bus.pin_in.status;
        m_btn_prev = bus.botao_interno;
        master = same_pin(bus.pin_in.digit, bus.data_setup.master_pin);
        valid  = master || any_user_slot(bus.pin_in.digit, bus.data_setup);
        case (m_mode)
            M_LOCKED: begin
                if (be) begin
                    m_mode = M_UNLOCKED; m_cnt = 0;
                end else if (pe && valid) begin
                    m_mode = M_UNLOCKED; m_cnt = 0; m_fail = 0;
                end else if (pe) begin
                    m_fail = (m_fail < 15) ? m_fail + 1 : 15;
                    if (m_fail >= 3) begin
                        m_mode = M_BLOCKED;
                        m_secs = (m_fail > 5) ? 20 : ((m_fail == 5) ? 10 : 1);
                    end
                end
            end
            M_BLOCKED: begin
                if (be) begin
                    m_mode = M_UNLOCKED; m_secs = 0; m_cnt = 0;
                end else if (bus.sec_tick) begin
                    m_secs--;
                    if (m_secs <= 0) begin
                        m_secs = 0; m_mode = M_LOCKED;
                    end
                end
            end
            M_UNLOCKED: begin
                if (bus.sensor_porta) begin
                    m_mode = M_OPEN; m_cnt = 0;
                    m_bip = bus.data_setup.bip_status && (bus.data_setup.bip_time == 0);
                end else if (be) begin
                    m_mode = M_LOCKED;
                end else if (bus.sec_tick && (m_cnt + 1 >= int'(bus.data_setup.tranca_aut_time))) begin
                    m_mode = M_LOCKED;
                end else if (pe && master) begin
                    m_mode = M_SETUP; m_cnt = 0;
                end else if (bus.sec_tick) begin
                    m_cnt++;
                end
            end
            M_OPEN: begin
                if (!bus.sensor_porta) begin
                    m_mode = M_UNLOCKED; m_cnt = 0; m_bip = 0;
                end else begin
                    if (bus.sec_tick && m_cnt < 127) m_cnt++;
                    m_bip = bus.data_setup.bip_status && (m_cnt >= int'(bus.data_setup.bip_time));
                end
            end
            default: begin
                if (bus.setup_done) begin
                    m_mode = M_UNLOCKED; m_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("tranca", 32'(bus.tranca), 32'(m_mode == M_LOCKED || m_mode == M_BLOCKED));
        check_val("bloqueado", 32'(bus.bloqueado), 32'(m_mode == M_BLOCKED));
        check_val("seg_restante", 32'(bus.seg_restante), 32'(m_secs));
        check_val("setup_on", 32'(bus.setup_on), 32'(m_mode == M_SETUP));
        check_val("bip", 32'(bus.bip), 32'(m_bip));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic enter_pin(input pin_digits_t d);
        bus.pin_in.digit  = d;
        bus.pin_in.status = 1'b1;
        cycle();
        cycle();
        bus.pin_in.status = 1'b0;
        cycle();
    endtask

    task automatic tick();
        bus.sec_tick = 1'b1;
        cycle();
        bus.sec_tick = 1'b0;
        cycle();
    endtask

    task automatic press();
        bus.botao_interno = 1'b1;
        cycle();
        bus.botao_interno = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_tranca", 32'(bus.tranca), 32'd1);
        check_val("async_rst_bloqueado", 32'(bus.bloqueado), 32'd0);
        check_val("async_rst_seg", 32'(bus.seg_restante), 32'd0);
        check_val("async_rst_setup_on", 32'(bus.setup_on), 32'd0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    initial begin
        bus.sec_tick = 0; bus.pin_in = '0; bus.sensor_porta = 0;
        bus.botao_interno = 0; bus.setup_done = 0;
        bus.data_setup = '0;
        bus.data_setup.pins[0].status = 1'b1;
        bus.data_setup.pins[0].digit  = 16'h1234;
        bus.data_setup.pins[1].digit  = 16'h5678;
        bus.data_setup.master_pin     = 16'h9999;
        bus.data_setup.bip_status     = 1'b1;
        bus.data_setup.bip_time       = 7'd3;
        bus.data_setup.tranca_aut_time = 7'd5;
        model_reset();

        cycle();
        cycle();
        check_val("reset_tranca", 32'(bus.tranca), 32'd1);
        check_val("reset_seg", 32'(bus.seg_restante), 32'd0);
        rst = 1'b1;
        cycle();

        // Valid user PIN unlocks one cycle after the status edge.
        bus.pin_in.digit = 16'h1234; bus.pin_in.status = 1'b1;
        cycle();
        check_val("pin_unlock_next_cycle", 32'(bus.tranca), 32'd0);
        cycle();
        bus.pin_in.status = 1'b0;
        cycle();
        press();
        check_val("btn_relock", 32'(bus.tranca), 32'd1);

        // Lockout thresholds; a PIN during lockout is not counted.
        repeat (3) enter_pin(16'h0000);
        check_val("fail3_bloqueado", 32'(bus.bloqueado), 32'd1);
        check_val("fail3_seg", 32'(bus.seg_restante), 32'd1);
        enter_pin(16'h0000);
        check_val("pin_in_lockout_seg", 32'(bus.seg_restante), 32'd1);
        tick();
        check_val("lock1_expired", 32'(bus.bloqueado), 32'd0);
        enter_pin(16'h0000);
        check_val("fail4_seg", 32'(bus.seg_restante), 32'd1);
        tick();
        enter_pin(16'h0000);
        check_val("fail5_seg", 32'(bus.seg_restante), 32'd10);
        repeat (10) tick();
        check_val("lock10_expired", 32'(bus.bloqueado), 32'd0);
        enter_pin(16'h1234);
        check_val("unlock_after_lockout", 32'(bus.tranca), 32'd0);

        // Auto relock on the fifth tick.
        repeat (4) tick();
        check_val("relock_before_5", 32'(bus.tranca), 32'd0);
        tick();
        check_val("relock_at_5", 32'(bus.tranca), 32'd1);

        // Door open buzzer, then close and restart the relock count.
        press();
        bus.sensor_porta = 1'b1;
        cycle();
        repeat (2) tick();
        check_val("bip_before_3", 32'(bus.bip), 32'd0);
        tick();
        check_val("bip_at_3", 32'(bus.bip), 32'd1);
        press();
        check_val("open_ignores_btn", 32'(bus.tranca), 32'd0);
        bus.sensor_porta = 1'b0;
        cycle();
        check_val("close_bip_off", 32'(bus.bip), 32'd0);
        repeat (4) tick();
        check_val("close_relock_before_5", 32'(bus.tranca), 32'd0);
        tick();
        check_val("close_relock_at_5", 32'(bus.tranca), 32'd1);

        // Master PIN into setup and back.
        press();
        enter_pin(16'h9999);
        check_val("setup_on", 32'(bus.setup_on), 32'd1);
        press();
        repeat (6) tick();
        check_val("setup_holds", 32'(bus.setup_on), 32'd1);
        bus.setup_done = 1'b1;
        cycle();
        bus.setup_done = 1'b0;
        check_val("setup_done_exit", 32'(bus.setup_on), 32'd0);
        check_val("setup_done_unlocked", 32'(bus.tranca), 32'd0);
        press();

        // Disabled slot is rejected and counts as a failure.
        enter_pin(16'h5678);
        check_val("slot_off_rejected", 32'(bus.tranca), 32'd1);
        enter_pin(16'h0000);
        check_val("fail2_no_lock", 32'(bus.bloqueado), 32'd0);
        enter_pin(16'h0000);
        check_val("slot_off_counted", 32'(bus.bloqueado), 32'd1);
        tick();

        // Blank digit compares as zero.
        bus.data_setup.pins[2].status = 1'b1;
        bus.data_setup.pins[2].digit  = 16'h1E04;
        enter_pin(16'h1004);
        check_val("blank_maps_zero", 32'(bus.tranca), 32'd0);
        press();

        // Button and wrong PIN together in TRAVADO: button wins.
        bus.pin_in.digit = 16'h0000; bus.pin_in.status = 1'b1; bus.botao_interno = 1'b1;
        cycle();
        check_val("btn_beats_pin", 32'(bus.tranca), 32'd0);
        bus.pin_in.status = 1'b0; bus.botao_interno = 1'b0;
        cycle();
        // Door sensor and button together in DESTRAVADO: door wins.
        bus.sensor_porta = 1'b1; bus.botao_interno = 1'b1;
        cycle();
        check_val("door_beats_btn", 32'(bus.tranca), 32'd0);
        bus.sensor_porta = 1'b0; bus.botao_interno = 1'b0;
        cycle();
        press();

        // Drive into a long lockout and reset mid-countdown.
        repeat (3) enter_pin(16'h0000);
        tick();
        enter_pin(16'h0000);
        tick();
        enter_pin(16'h0000);
        repeat (10) tick();
        enter_pin(16'h0000);
        check_val("fail6_seg", 32'(bus.seg_restante), 32'd20);
        repeat (13) tick();
        check_val("seg_7_before_reset", 32'(bus.seg_restante), 32'd7);
        do_reset();
        enter_pin(16'h0000);
        enter_pin(16'h0000);
        check_val("post_reset_fail2", 32'(bus.bloqueado), 32'd0);
        enter_pin(16'h0000);
        check_val("post_reset_fail3", 32'(bus.bloqueado), 32'd1);
        tick();

        // Random phase.
        for (int n = 0; n < 4000; n++) begin
            if (n % 800 == 0) begin
                for (int s = 0; s < 4; s++) begin
                    bus.data_setup.pins[s].status = 1'($urandom_range(0, 1));
                    bus.data_setup.pins[s].digit  = 16'($urandom);
                end
                bus.data_setup.master_pin      = 16'($urandom);
                bus.data_setup.bip_status      = 1'($urandom_range(0, 1));
                bus.data_setup.bip_time        = 7'($urandom_range(0, 4));
                bus.data_setup.tranca_aut_time = 7'($urandom_range(0, 6));
            end
            bus.sec_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) begin
                if (!bus.pin_in.status) begin
                    case ($urandom_range(0, 4))
                        0: bus.pin_in.digit = bus.data_setup.pins[0].digit;
                        1: bus.pin_in.digit = bus.data_setup.pins[1].digit;
                        2: bus.pin_in.digit = bus.data_setup.master_pin;
                        default: bus.pin_in.digit = 16'($urandom);
                    endcase
                end
                bus.pin_in.status = ~bus.pin_in.status;
            end
            if ($urandom_range(0, 24) == 0) bus.sensor_porta = ~bus.sensor_porta;
            if ($urandom_range(0, 7) == 0) bus.botao_interno = ~bus.botao_interno;
            bus.setup_done = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1499) == 0) do_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
